// File: rtl/traffic_seg_monitor.sv
// ============================================================================
// traffic_seg_monitor : decodes controller seg output, checks phase order/dwell
// Rev 1.0
// ============================================================================
`default_nettype none

module traffic_seg_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 255,
  parameter int DWELL_W   = 8,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         seg,
  output logic [1:0]         light,
  output logic [DWELL_W-1:0] dwell,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               fault,
  output logic               err_pulse,
  output logic [2:0]         err_code
);

  localparam logic [1:0] c_GREEN   = 2'b00;
  localparam logic [1:0] c_YELLOW  = 2'b01;
  localparam logic [1:0] c_RED     = 2'b10;
  localparam logic [1:0] c_NONE    = 2'b11;

  localparam logic [2:0] c_ERR_NONE    = 3'd0;
  localparam logic [2:0] c_ERR_BAD     = 3'd1;
  localparam logic [2:0] c_ERR_ILLEGAL = 3'd2;
  localparam logic [2:0] c_ERR_SHORT   = 3'd3;
  localparam logic [2:0] c_ERR_STUCK   = 3'd4;

  localparam logic [DWELL_W-1:0] c_MIN      = DWELL_W'(MIN_DWELL);
  localparam logic [DWELL_W-1:0] c_MAX      = DWELL_W'(MAX_DWELL);
  localparam logic [DWELL_W-1:0] c_DW_ONE   = DWELL_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);
  localparam bit                 c_STUCK_EN = (MAX_DWELL != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_RED    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t               r_state;
  logic [1:0]           r_light;
  logic [DWELL_W-1:0]   r_dwell;
  logic [CNT_W-1:0]     r_cycle;
  logic                 r_fault;
  logic                 r_err_pulse;
  logic [2:0]           r_err_code;

  logic [1:0]           w_dec;
  logic                 w_valid;
  logic [1:0]           w_next;
  logic                 w_in_colour;
  logic [2:0]           w_err;

  function automatic state_t colour_state(input logic [1:0] code);
    case (code)
      c_GREEN:  colour_state = S_GREEN;
      c_YELLOW: colour_state = S_YELLOW;
      default:  colour_state = S_RED;
    endcase
  endfunction

  always_comb begin
    case (seg)
      8'b0111_0111: w_dec = c_GREEN;
      8'b0111_0110: w_dec = c_YELLOW;
      8'b0000_1110: w_dec = c_RED;
      default:      w_dec = c_NONE;
    endcase
  end

  assign w_valid     = (w_dec != c_NONE);
  assign w_in_colour = (r_state == S_GREEN) || (r_state == S_YELLOW) || (r_state == S_RED);

  always_comb begin
    case (r_light)
      c_GREEN:  w_next = c_YELLOW;
      c_YELLOW: w_next = c_RED;
      default:  w_next = c_GREEN;
    endcase
  end

  // Only colour states can raise an error; IDLE and FAULT absorb anything.
  always_comb begin
    w_err = c_ERR_NONE;
    if (w_in_colour) begin
      if (!w_valid) begin
        w_err = c_ERR_BAD;
      end else if (w_dec == r_light) begin
        if (c_STUCK_EN && (r_dwell == c_MAX)) w_err = c_ERR_STUCK;
      end else if (w_dec == w_next) begin
        if (r_dwell < c_MIN) w_err = c_ERR_SHORT;
      end else begin
        w_err = c_ERR_ILLEGAL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_light     <= c_NONE;
      r_dwell     <= '0;
      r_cycle     <= '0;
      r_fault     <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_code  <= c_ERR_NONE;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_err != c_ERR_NONE) begin
        r_state     <= S_FAULT;
        r_light     <= c_NONE;
        r_dwell     <= '0;
        r_fault     <= 1'b1;
        r_err_pulse <= 1'b1;
        r_err_code  <= w_err;
      end else if (!w_in_colour) begin
        if (w_valid) begin
          r_state <= colour_state(w_dec);
          r_light <= w_dec;
          r_dwell <= c_DW_ONE;
          r_fault <= 1'b0;
        end
      end else if (w_dec == r_light) begin
        if (r_dwell != '1) r_dwell <= r_dwell + c_DW_ONE;
      end else begin
        // No error and a different colour: must be the legal successor.
        r_state <= colour_state(w_dec);
        r_light <= w_dec;
        r_dwell <= c_DW_ONE;
        if (r_light == c_RED) r_cycle <= r_cycle + c_CNT_ONE;
      end
    end
  end

  assign light       = r_light;
  assign dwell       = r_dwell;
  assign cycle_count = r_cycle;
  assign fault       = r_fault;
  assign err_pulse   = r_err_pulse;
  assign err_code    = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_traffic_seg_monitor.sv
// ============================================================================
// tb_traffic_seg_monitor : directed self-checking bench for traffic_seg_monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_traffic_seg_monitor;

  localparam logic [7:0] c_G   = 8'b0111_0111;
  localparam logic [7:0] c_Y   = 8'b0111_0110;
  localparam logic [7:0] c_R   = 8'b0000_1110;
  localparam logic [7:0] c_BAD = 8'hFF;

  logic clk;
  logic reset;

  // Instance A: defaults
  logic [7:0]  seg_a;
  logic [1:0]  light_a;
  logic [7:0]  dwell_a;
  logic [15:0] cyc_a;
  logic        fault_a, pulse_a;
  logic [2:0]  code_a;

  // Instance B: MAX_DWELL=4
  logic [7:0]  seg_b;
  logic [1:0]  light_b;
  logic [7:0]  dwell_b;
  logic [15:0] cyc_b;
  logic        fault_b, pulse_b;
  logic [2:0]  code_b;

  // Instance C: MIN_DWELL=2
  logic [7:0]  seg_c;
  logic [1:0]  light_c;
  logic [7:0]  dwell_c;
  logic [15:0] cyc_c;
  logic        fault_c, pulse_c;
  logic [2:0]  code_c;

  // Instance D: CNT_W=2
  logic [7:0]  seg_d;
  logic [1:0]  light_d;
  logic [7:0]  dwell_d;
  logic [1:0]  cyc_d;
  logic        fault_d, pulse_d;
  logic [2:0]  code_d;

  int n_asserts;
  int n_fail;

  traffic_seg_monitor u_dut_a (
    .clk(clk), .reset(reset), .seg(seg_a), .light(light_a), .dwell(dwell_a),
    .cycle_count(cyc_a), .fault(fault_a), .err_pulse(pulse_a), .err_code(code_a)
  );

  traffic_seg_monitor #(.MAX_DWELL(4)) u_dut_b (
    .clk(clk), .reset(reset), .seg(seg_b), .light(light_b), .dwell(dwell_b),
    .cycle_count(cyc_b), .fault(fault_b), .err_pulse(pulse_b), .err_code(code_b)
  );

  traffic_seg_monitor #(.MIN_DWELL(2)) u_dut_c (
    .clk(clk), .reset(reset), .seg(seg_c), .light(light_c), .dwell(dwell_c),
    .cycle_count(cyc_c), .fault(fault_c), .err_pulse(pulse_c), .err_code(code_c)
  );

  traffic_seg_monitor #(.CNT_W(2)) u_dut_d (
    .clk(clk), .reset(reset), .seg(seg_d), .light(light_d), .dwell(dwell_d),
    .cycle_count(cyc_d), .fault(fault_d), .err_pulse(pulse_d), .err_code(code_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_wrap [5];
    exp_wrap[0] = 2'd1; exp_wrap[1] = 2'd2; exp_wrap[2] = 2'd3;
    exp_wrap[3] = 2'd0; exp_wrap[4] = 2'd1;

    n_asserts = 0;
    n_fail    = 0;
    reset = 1'b1;
    seg_a = 8'h00; seg_b = 8'h00; seg_c = 8'h00; seg_d = 8'h00;
    tick();
    tick();

    check("rst_light", light_a, 2'b11);
    check("rst_dwell", dwell_a, 0);
    check("rst_cycle", cyc_a, 0);
    check("rst_fault", fault_a, 0);
    check("rst_pulse", pulse_a, 0);
    check("rst_code",  code_a, 0);
    reset = 1'b0;

    // Power-up garbage in IDLE
    seg_a = c_BAD; tick();
    check("idle_garbage_light", light_a, 2'b11);
    check("idle_garbage_pulse", pulse_a, 0);

    // Nominal G Y R G Y
    seg_a = c_G; tick();
    check("nom_g_light", light_a, 2'b00);
    check("nom_g_dwell", dwell_a, 1);
    seg_a = c_Y; tick();
    check("nom_y_light", light_a, 2'b01);
    check("nom_y_dwell", dwell_a, 1);
    seg_a = c_R; tick();
    check("nom_r_light", light_a, 2'b10);
    check("nom_r_cycle", cyc_a, 0);
    seg_a = c_G; tick();
    check("nom_g2_light", light_a, 2'b00);
    check("nom_g2_cycle", cyc_a, 1);
    seg_a = c_Y; tick();
    check("nom_y2_light", light_a, 2'b01);
    check("nom_y2_dwell", dwell_a, 1);
    check("nom_y2_cycle", cyc_a, 1);
    check("nom_y2_code",  code_a, 0);

    // Dwell counts while a phase is held
    tick();
    check("hold_y_dwell", dwell_a, 2);

    // Illegal sequence: reach GREEN, then jump to RED
    seg_a = c_R; tick();
    seg_a = c_G; tick();
    check("ill_pre_cycle", cyc_a, 2);
    seg_a = c_R; tick();
    check("ill_pulse", pulse_a, 1);
    check("ill_code",  code_a, 2);
    check("ill_fault", fault_a, 1);
    check("ill_light", light_a, 2'b11);
    check("ill_dwell", dwell_a, 0);
    seg_a = c_Y; tick();
    check("resync_light", light_a, 2'b01);
    check("resync_fault", fault_a, 0);
    check("resync_pulse", pulse_a, 0);
    check("resync_code",  code_a, 2);
    check("resync_dwell", dwell_a, 1);

    // Bad pattern from YELLOW, held
    seg_a = c_BAD; tick();
    check("bad_code",  code_a, 1);
    check("bad_fault", fault_a, 1);
    check("bad_pulse", pulse_a, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bad_hold_pulse", pulse_a, 0);
      check("bad_hold_fault", fault_a, 1);
    end

    // Resync into GREEN does not count a cycle; then run to RED with count 3
    seg_a = c_G; tick();
    check("resync_g_cycle", cyc_a, 2);
    check("resync_g_light", light_a, 2'b00);
    seg_a = c_Y; tick();
    seg_a = c_R; tick();
    seg_a = c_G; tick();
    check("pre_rst_cycle", cyc_a, 3);
    seg_a = c_Y; tick();
    seg_a = c_R; tick();
    check("pre_rst_light", light_a, 2'b10);

    // Asynchronous reset between edges
    reset = 1'b1;
    #1;
    check("arst_light", light_a, 2'b11);
    check("arst_dwell", dwell_a, 0);
    check("arst_cycle", cyc_a, 0);
    check("arst_fault", fault_a, 0);
    check("arst_pulse", pulse_a, 0);
    check("arst_code",  code_a, 0);
    #1;
    reset = 1'b0;
    seg_a = c_Y; tick();
    check("post_rst_light", light_a, 2'b01);
    check("post_rst_pulse", pulse_a, 0);
    check("post_rst_fault", fault_a, 0);
    check("post_rst_dwell", dwell_a, 1);
    seg_a = 8'h00;

    // MAX_DWELL=4: GREEN held 5 samples
    seg_b = c_G;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("max_dwell", dwell_b, i);
      check("max_light", light_b, 2'b00);
    end
    tick();
    check("stuck_code",  code_b, 4);
    check("stuck_pulse", pulse_b, 1);
    check("stuck_fault", fault_b, 1);
    check("stuck_light", light_b, 2'b11);
    seg_b = 8'h00;

    // MIN_DWELL=2: one GREEN then YELLOW is too short
    seg_c = c_G; tick();
    seg_c = c_Y; tick();
    check("short_code",  code_c, 3);
    check("short_pulse", pulse_c, 1);
    check("short_fault", fault_c, 1);

    // MIN_DWELL=2: two GREEN then YELLOW is legal
    pulse_reset();
    seg_c = c_G; tick();
    tick();
    check("min_ok_dwell", dwell_c, 2);
    seg_c = c_Y; tick();
    check("min_ok_light", light_c, 2'b01);
    check("min_ok_pulse", pulse_c, 0);
    check("min_ok_code",  code_c, 0);
    check("min_ok_fault", fault_c, 0);
    seg_c = 8'h00;

    // CNT_W=2: wrap after 4 cycles
    pulse_reset();
    seg_d = c_G; tick();
    check("wrap_start", cyc_d, 0);
    for (int i = 0; i < 5; i++) begin
      seg_d = c_Y; tick();
      seg_d = c_R; tick();
      seg_d = c_G; tick();
      check("wrap_cycle", cyc_d, exp_wrap[i]);
    end
    check("wrap_code", code_d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traffic_seg_monitor.md
# traffic_seg_monitor

Receive-side checker for the traffic light controller's 8-bit segment output. It decodes the `seg` pattern back into a light phase and tracks the GREEN→YELLOW→RED→GREEN sequence and per-phase dwell time. It flags bad patterns, illegal transitions and dwell violations, and counts completed light cycles. It sits downstream of the controller, on the same clock, as an on-chip monitor and a self-checking aid for benches.

## Interface
Parameters:
- `MIN_DWELL`, default 1: minimum consecutive samples of a phase before leaving it is legal (≥1).
- `MAX_DWELL`, default 255: maximum consecutive samples of one phase; 0 disables the stuck check.
- `DWELL_W`, default 8: width of the dwell counter; must hold `MAX_DWELL`.
- `CNT_W`, default 16: width of the completed-cycle counter.

Ports:
- `clk` in, 1: rising-edge clock.
- `reset` in, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `seg` in, 8: segment pattern from the controller.
- `light` out, 2: current phase. 00 GREEN, 01 YELLOW, 10 RED, 11 none (IDLE/FAULT).
- `dwell` out, DWELL_W: consecutive samples of the current phase, including the entering sample.
- `cycle_count` out, CNT_W: completed RED→GREEN transitions; wraps modulo 2^CNT_W.
- `fault` out, 1: high while the FSM is in FAULT.
- `err_pulse` out, 1: one-cycle pulse on each detected error.
- `err_code` out, 3: last error detected, sticky until reset. 0 none, 1 BAD_PATTERN, 2 ILLEGAL_SEQ, 3 SHORT_DWELL, 4 STUCK.

## Operation
- Combinational decode `d` from `seg`:
  - 8'b01110111 → GREEN.
  - 8'b01110110 → YELLOW.
  - 8'b00001110 → RED.
  - Anything else → UNKNOWN.
- FSM states: IDLE, GREEN, YELLOW, RED, FAULT. Evaluation happens on every rising `clk`.
- IDLE:
  - `d` is a valid colour → go to that colour, dwell=1.
  - `d` is UNKNOWN → stay in IDLE, no error. Power-up garbage is tolerated.
- Colour state S, with `next(S)` defined as G→Y, Y→R, R→G:
  - `d`==S and (MAX_DWELL==0 or dwell<MAX_DWELL) → stay in S. dwell+1, saturating at all-ones.
  - `d`==S and dwell==MAX_DWELL (MAX_DWELL≠0) → STUCK, go to FAULT.
  - `d`==next(S) and dwell≥MIN_DWELL → go to next(S), dwell=1. If the transition is R→G, cycle_count+1.
  - `d`==next(S) and dwell<MIN_DWELL → SHORT_DWELL, go to FAULT.
  - `d` is any other valid colour (skip or backward) → ILLEGAL_SEQ, go to FAULT.
  - `d` is UNKNOWN → BAD_PATTERN, go to FAULT.
- FAULT:
  - `d` is a valid colour → resync into that colour, dwell=1, no cycle_count increment, no error.
  - `d` is UNKNOWN → stay in FAULT, no further error pulse.
- Error reporting: on entry to FAULT, `err_pulse`=1 for exactly one cycle and `err_code` is loaded. At most one error can occur per cycle, so no priority logic is needed.
- dwell=0 in IDLE and FAULT.

## Timing
- All outputs are registered. `seg` sampled at edge k is reflected on outputs immediately after edge k (1-cycle latency from input change to output).
- Reset values, applied asynchronously on `reset` high:
  - state=IDLE, `light`=11, `dwell`=0, `cycle_count`=0.
  - `fault`=0, `err_pulse`=0, `err_code`=0.
- Reset asserted mid-sequence clears all outputs immediately, without waiting for a clock. After deassertion, the first valid colour is accepted from IDLE with no error, whatever the phase order.
- cycle_count wrap: all-ones + 1 → 0, with no flag.
- The dwell counter must not overflow when MAX_DWELL=0. It holds at 2^DWELL_W−1.

## Test plan
- **Nominal sequence.** MIN=1, MAX=255. After reset, drive GREEN, YELLOW, RED, GREEN, YELLOW for one cycle each. Required: `light` goes 00, 01, 10, 00, 01 with 1-cycle lag; `dwell`=1 throughout; `cycle_count`=1; `err_code`=0.
- **Illegal sequence.** Drive GREEN then RED. Required: one cycle after RED is sampled, `err_pulse`=1 for one cycle, `err_code`=2, `fault`=1, `light`=11. Then drive YELLOW: required resync, `light`=01, `fault`=0, `err_code` still 2.
- **Bad pattern.** From YELLOW, drive 8'hFF. Required: `err_code`=1, `fault`=1. Hold 8'hFF for 3 cycles: required no further `err_pulse`.
- **Dwell limits.**
  - MAX=4: hold GREEN for 5 samples. Required: `dwell` 1..4, then STUCK (`err_code`=4) on the 5th sample.
  - MIN=2: drive GREEN for 1 cycle then YELLOW. Required: `err_code`=3.
  - MIN=2: drive GREEN for 2 cycles then YELLOW. Required: legal transition, no error.
- **Reset mid-operation.** In RED with `cycle_count`=3, assert `reset` between clock edges. Required: all outputs at reset values before the next edge. After release, YELLOW is accepted from IDLE with no error.
- **Counter wrap.** CNT_W=2: run 5 full G→Y→R→G cycles. Required: `cycle_count` sequence 1, 2, 3, 0, 1.
